stack_job_arbiter: RTL and testbench
====================================

STACK_JOB_ARBITER -- requirements
Module: stack_job_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 4096: maximum cycles allowed from start issue to processor ready return.
REQ-002 Parameter TW, default 16: width of the timeout counter; TIMEOUT SHALL be at most 2**TW.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 r0_req / r1_req  in  1  requester 0/1 wants the processor.
REQ-006 r0_go / r1_go  in  1  requester program loaded; run it.
REQ-007 r0_wr / r1_wr  in  1  requester program-word write strobe.
REQ-008 r0_addr / r1_addr  in  10  requester program-word address.
REQ-009 r0_data / r1_data  in  16  requester program word.
REQ-010 gnt  out  2  one-hot grant; bit i means requester i owns the processor.
REQ-011 done  out  2  one-cycle completion pulse, one bit per requester.
REQ-012 err  out  1  valid with done; 1 means the job timed out.
REQ-013 result  out  16  processor top-of-stack captured at completion; held until the next done.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 p_wr, p_addr[9:0], p_datain[15:0], p_start  out  drive the stack processor's load/start port.
REQ-016 p_ready, p_out[15:0]  in  processor ready flag and output.
REQ-017 p_nrst  out  1  registered active-low reset to the processor.

Function
REQ-018 States SHALL be IDLE, LOAD, START, RUN, ABORT and DONE.
REQ-019 IDLE with any req high: the grant SHALL be round-robin.
- Both requesting: grant the requester not served last.
- Requester 0 SHALL win the first contention after reset.
- Next cycle: state LOAD, gnt one-hot.
REQ-020 LOAD: p_wr, p_addr and p_datain SHALL combinationally follow the granted requester's wr/addr/data.
- In every other state p_wr = 0, p_addr = 0 and p_datain = 0.
REQ-021 LOAD with the granted go high: next state START; the timeout counter clears to 0.
- Writes in the same cycle are still forwarded.
REQ-022 LOAD with the granted req low and go low: the grant is released and the state returns to IDLE with no done pulse.
- This counts as "served" for round-robin.
REQ-023 START: p_start = 1 until p_ready = 0 is sampled, then RUN.
REQ-024 RUN: p_start = 0; the job completes when p_ready = 1 is sampled.
- That cycle: result <= p_out, err <= 0, next state DONE.
REQ-025 The timeout counter SHALL increment every cycle in START and RUN.
- If it reaches TIMEOUT-1 without completion, next state is ABORT.
- Completion and timeout in the same cycle: completion wins.
REQ-026 ABORT lasts exactly one cycle with p_nrst = 0.
- Then DONE with err <= 1 and result <= 0.
REQ-027 DONE lasts one cycle: done[i] = 1 for the granted i only.
- gnt SHALL remain asserted during DONE and clear on the next cycle.
- State then IDLE; new arbitration SHALL NOT occur before the cycle after DONE.
REQ-028 gnt SHALL change only on IDLE->LOAD and DONE/LOAD->IDLE transitions.
- gnt, done and p_start SHALL never have more than one requester bit set.
REQ-029 go or wr from a non-granted requester SHALL be ignored with no side effect.
- go asserted in IDLE is not remembered.
REQ-030 p_nrst SHALL be 1 in all states except ABORT and reset.

Reset
REQ-031 While rst is high, and on the first cycle after it falls, outputs SHALL hold these values:
- state IDLE; gnt = 0; done = 0; err = 0; result = 0; busy = 0; p_start = 0; p_nrst = 0; round-robin pointer set so requester 0 wins.
REQ-032 p_nrst SHALL return to 1 on the first clock edge with rst low.
REQ-033 rst mid-job (any state) SHALL abort without a done pulse and reset the processor through p_nrst.

Verification
REQ-034 Single job.
- Stimulus: r0 granted; write 0x0005, 0x0007, 0x8002, 0xC000 at addresses 0..3; then go.
- Required: done = 2'b01, err = 0, result = 0x000C.
REQ-035 Contention.
- Stimulus: r0_req and r1_req high together after reset.
- Required: gnt 01, job, done 01; then gnt 10, done 10; the next contention grants 01.
REQ-036 Timeout.
- Stimulus: TIMEOUT = 64; program 0x0000, 0x8007 (self-loop); go.
- Required: p_nrst low for exactly one cycle about 64 cycles after p_start; then done with err = 1 and result = 0.
REQ-037 Withdrawal.
- Stimulus: r1 granted, writes two words, drops req without go.
- Required: IDLE, no done, p_start never asserted.
REQ-038 Isolation.
- Stimulus: r1_wr pulses while r0 is in LOAD.
- Required: p_wr and p_addr reflect r0 only.
REQ-039 Reset mid-RUN.
- Stimulus: rst asserted mid-RUN.
- Required: gnt = 0, done never pulses, p_nrst = 0 while rst is high; a new job afterwards returns the correct result.

Source files
------------

// File: rtl/stack_job_arbiter.sv
// stack_job_arbiter
//   Shares one stack processor between two requesters. A granted requester
//   streams its program into the processor through the load port, then
//   issues go; the arbiter starts the processor, waits for ready, and
//   reports the top-of-stack with a one-cycle done pulse. A job that runs
//   past TIMEOUT cycles is aborted by pulsing the processor reset, and
//   completes with err = 1 and result = 0.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   rN_req/go/wr/addr/data    requester N (N = 0, 1) request and load port
//   gnt[1:0]                  one-hot owner of the processor
//   done[1:0], err, result    completion pulse, timeout flag, result word
//   busy                      arbiter not idle
//   p_wr/p_addr/p_datain      processor program-load port
//   p_start                   processor start request
//   p_ready, p_out            processor ready flag and top-of-stack
//   p_nrst                    registered active-low processor reset
module stack_job_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int TW      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic        r0_go,
  input  logic        r1_go,
  input  logic        r0_wr,
  input  logic        r1_wr,
  input  logic [9:0]  r0_addr,
  input  logic [9:0]  r1_addr,
  input  logic [15:0] r0_data,
  input  logic [15:0] r1_data,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [15:0] result,
  output logic        busy,
  output logic        p_wr,
  output logic [9:0]  p_addr,
  output logic [15:0] p_datain,
  output logic        p_start,
  input  logic        p_ready,
  input  logic [15:0] p_out,
  output logic        p_nrst
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_ABORT,
    S_DONE
  } state_t;

  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   result_q, result_d;
  logic          p_start_q, p_start_d;
  logic          p_nrst_q, p_nrst_d;
  logic [TW-1:0] cnt_q, cnt_d;
  // Index of the requester served most recently; reset to 1 so that
  // requester 0 wins the first contention.
  logic          last_q, last_d;

  // Signals of whichever requester currently holds the grant.
  logic          sel;
  logic          sel_req;
  logic          sel_go;
  logic          pick;

  always_comb begin
    sel     = gnt_q[1];
    sel_req = sel ? r1_req : r0_req;
    sel_go  = sel ? r1_go  : r0_go;
    // Both requesting: take the one not served last.
    pick    = (r0_req && r1_req) ? ~last_q : r1_req;
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = 2'b00;
    err_d     = err_q;
    result_d  = result_q;
    p_start_d = p_start_q;
    p_nrst_d  = 1'b1;
    cnt_d     = cnt_q;
    last_d    = last_q;

    case (state_q)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          state_d = S_LOAD;
          gnt_d   = pick ? 2'b10 : 2'b01;
          last_d  = pick;
        end
      end

      S_LOAD: begin
        if (sel_go) begin
          state_d   = S_START;
          p_start_d = 1'b1;
          cnt_d     = '0;
        end else if (!sel_req) begin
          state_d = S_IDLE;
          gnt_d   = 2'b00;
        end
      end

      // No completion is possible before the processor has acknowledged
      // the start, so the timeout takes priority here.
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          state_d   = S_ABORT;
          p_start_d = 1'b0;
          p_nrst_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + TW'(1);
          if (!p_ready) begin
            state_d   = S_RUN;
            p_start_d = 1'b0;
          end
        end
      end

      // Completion is checked first so it wins over a same-cycle timeout.
      S_RUN: begin
        if (p_ready) begin
          state_d  = S_DONE;
          result_d = p_out;
          err_d    = 1'b0;
          done_d   = gnt_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = S_ABORT;
          p_nrst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      S_ABORT: begin
        state_d  = S_DONE;
        err_d    = 1'b1;
        result_d = '0;
        done_d   = gnt_q;
      end

      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      err_q     <= 1'b0;
      result_q  <= '0;
      p_start_q <= 1'b0;
      p_nrst_q  <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      result_q  <= result_d;
      p_start_q <= p_start_d;
      p_nrst_q  <= p_nrst_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  // Load port passes the owner's strobes straight through, only in LOAD.
  always_comb begin
    p_wr     = 1'b0;
    p_addr   = '0;
    p_datain = '0;
    if (state_q == S_LOAD) begin
      p_wr     = sel ? r1_wr   : r0_wr;
      p_addr   = sel ? r1_addr : r0_addr;
      p_datain = sel ? r1_data : r0_data;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign result  = result_q;
  assign busy    = (state_q != S_IDLE);
  assign p_start = p_start_q;
  assign p_nrst  = p_nrst_q;

endmodule

// File: tb/tb_stack_job_arbiter.sv
// Bench for stack_job_arbiter with a small behavioural stack processor:
//   0x0nnn..0x7fff push immediate, 0x8002 add, 0x8007 jump to popped
//   address, 0xCxxx halt (ready = 1, out = top of stack).
module tb_stack_job_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r0_req, r1_req, r0_go, r1_go, r0_wr, r1_wr;
  logic [9:0]  r0_addr, r1_addr;
  logic [15:0] r0_data, r1_data;
  logic [1:0]  gnt, done;
  logic        err, busy;
  logic [15:0] result;
  logic        p_wr, p_start, p_ready, p_nrst;
  logic [9:0]  p_addr;
  logic [15:0] p_datain, p_out;

  stack_job_arbiter #(.TIMEOUT(64), .TW(16)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r1_req(r1_req), .r0_go(r0_go), .r1_go(r1_go),
    .r0_wr(r0_wr), .r1_wr(r1_wr), .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_data(r0_data), .r1_data(r1_data),
    .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
    .p_wr(p_wr), .p_addr(p_addr), .p_datain(p_datain), .p_start(p_start),
    .p_ready(p_ready), .p_out(p_out), .p_nrst(p_nrst)
  );

  // Processor model
  logic [15:0] pmem [0:1023];
  logic [15:0] stk  [0:15];
  logic [3:0]  sp;
  logic [9:0]  pc;
  logic        running;
  logic [15:0] ins, top, sec;
  assign ins = pmem[pc];
  assign top = stk[sp - 4'd1];
  assign sec = stk[sp - 4'd2];

  always @(posedge clk) begin
    if (!p_nrst) begin
      running <= 1'b0; p_ready <= 1'b1; pc <= '0; sp <= '0; p_out <= '0;
    end else begin
      if (p_wr) pmem[p_addr] <= p_datain;
      if (!running) begin
        if (p_start) begin running <= 1'b1; p_ready <= 1'b0; pc <= '0; sp <= '0; end
      end else if (!ins[15]) begin
        stk[sp] <= {1'b0, ins[14:0]}; sp <= sp + 4'd1; pc <= pc + 10'd1;
      end else if (ins[14]) begin
        running <= 1'b0; p_ready <= 1'b1; p_out <= top;
      end else if (ins[13:0] == 14'd2) begin
        stk[sp - 4'd2] <= top + sec; sp <= sp - 4'd1; pc <= pc + 10'd1;
      end else if (ins[13:0] == 14'd7) begin
        pc <= top[9:0]; sp <= sp - 4'd1;
      end else begin
        pc <= pc + 10'd1;
      end
    end
  end

  // Scoreboard
  typedef struct packed { logic [1:0] d; logic e; logic [15:0] r; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;
  int   p_start_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    chk("onehot_gnt_done", {30'd0, $onehot0(gnt), $onehot0(done)}, 32'd3);
    if (p_start) p_start_cycles++;
    if (done != 2'b00) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {30'd0, done}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_bits", {30'd0, done}, {30'd0, mon_e.d});
        chk("err", {31'd0, err}, {31'd0, mon_e.e});
        chk("result", {16'd0, result}, {16'd0, mon_e.r});
      end
    end
  end

  // Stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v);
    if (r == 0) r0_req = v; else r1_req = v;
  endtask

  task automatic set_go(input int r, input logic v);
    if (r == 0) r0_go = v; else r1_go = v;
  endtask

  task automatic drive_wr(input int r, input logic wr, input logic [9:0] a, input logic [15:0] d);
    if (r == 0) begin r0_wr = wr; r0_addr = a; r0_data = d; end
    else        begin r1_wr = wr; r1_addr = a; r1_data = d; end
  endtask

  task automatic acquire(input int r, input logic [1:0] exp_gnt, input string name);
    set_req(r, 1'b1);
    for (int i = 0; i < 20 && gnt == 2'b00; i++) step();
    chk(name, {30'd0, gnt}, {30'd0, exp_gnt});
  endtask

  // kind 0: 5+7, kind 1: endless loop, kind 2: 3+4
  task automatic load_prog(input int r, input int kind);
    logic [15:0] w [4];
    int n;
    case (kind)
      0:       begin w = '{16'h0005, 16'h0007, 16'h8002, 16'hC000}; n = 4; end
      1:       begin w = '{16'h0000, 16'h8007, 16'h0000, 16'h0000}; n = 2; end
      default: begin w = '{16'h0003, 16'h0004, 16'h8002, 16'hC000}; n = 4; end
    endcase
    for (int i = 0; i < n; i++) begin
      drive_wr(r, 1'b1, 10'(i), w[i]);
      step();
    end
    drive_wr(r, 1'b0, 10'd0, 16'd0);
  endtask

  task automatic launch(input int r, input bit push, input logic e, input logic [15:0] res);
    exp_t x;
    if (push) begin
      x.d = (r == 0) ? 2'b01 : 2'b10; x.e = e; x.r = res;
      exp_q.push_back(x);
    end
    set_go(r, 1'b1);
    step();
    set_go(r, 1'b0);
    set_req(r, 1'b0);
  endtask

  task automatic wait_done(input string name);
    int start;
    int n;
    start = done_seen;
    n = 0;
    while (done_seen == start && n < 300) begin step(); n++; end
    chk(name, {31'd0, done_seen != start}, 32'd1);
  endtask

  initial begin
    int ps0, ds0, n;
    rst = 1'b1;
    r0_req = 0; r1_req = 0; r0_go = 0; r1_go = 0;
    drive_wr(0, 1'b0, 10'd0, 16'd0);
    drive_wr(1, 1'b0, 10'd0, 16'd0);

    // Reset state
    repeat (3) step();
    chk("rst_gnt", {30'd0, gnt}, 0);
    chk("rst_done", {30'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_result", {16'd0, result}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_p_start", {31'd0, p_start}, 0);
    chk("rst_p_nrst", {31'd0, p_nrst}, 0);
    rst = 1'b0;
    chk("rst_fall_p_nrst", {31'd0, p_nrst}, 0);
    step();
    chk("rst_release_p_nrst", {31'd0, p_nrst}, 1);

    // Contention: r0 first, then r1
    r0_req = 1; r1_req = 1;
    acquire(0, 2'b01, "cont_gnt_r0");
    load_prog(0, 0);
    launch(0, 1, 1'b0, 16'h000C);
    wait_done("cont_done_r0");
    acquire(1, 2'b10, "cont_gnt_r1");
    load_prog(1, 2);
    launch(1, 1, 1'b0, 16'h0007);
    wait_done("cont_done_r1");

    // Second contention grants r0; isolation of r1 strobes during r0 LOAD
    r0_req = 1; r1_req = 1;
    acquire(0, 2'b01, "cont2_gnt_r0");
    drive_wr(0, 1'b0, 10'd5, 16'h0000);
    drive_wr(1, 1'b1, 10'd0, 16'hDEAD);
    r1_go = 1;
    #1;
    chk("iso_p_wr", {31'd0, p_wr}, 0);
    chk("iso_p_addr", {22'd0, p_addr}, 5);
    chk("iso_p_datain", {16'd0, p_datain}, 0);
    step();
    r1_go = 0;
    chk("iso_go_ignored", {31'd0, p_start}, 0);
    chk("iso_gnt_held", {30'd0, gnt}, 2'b01);
    drive_wr(0, 1'b1, 10'd2, 16'h1234);
    drive_wr(1, 1'b1, 10'h3FF, 16'hBEEF);
    #1;
    chk("iso2_p_wr", {31'd0, p_wr}, 1);
    chk("iso2_p_addr", {22'd0, p_addr}, 2);
    chk("iso2_p_datain", {16'd0, p_datain}, 16'h1234);
    step();
    drive_wr(1, 1'b0, 10'd0, 16'd0);
    load_prog(0, 0);
    launch(0, 1, 1'b0, 16'h000C);
    wait_done("single_done");

    // Withdrawal: r1 (still requesting) is granted, writes, drops req
    acquire(1, 2'b10, "wd_gnt_r1");
    drive_wr(1, 1'b1, 10'd0, 16'h1111);
    step();
    drive_wr(1, 1'b1, 10'd1, 16'h2222);
    step();
    drive_wr(1, 1'b0, 10'd0, 16'd0);
    r1_req = 0;
    ps0 = p_start_cycles;
    ds0 = done_seen;
    step();
    chk("wd_gnt", {30'd0, gnt}, 0);
    chk("wd_busy", {31'd0, busy}, 0);
    repeat (5) step();
    chk("wd_no_start", p_start_cycles, ps0);
    chk("wd_no_done", done_seen, ds0);
    chk("wd_result_held", {16'd0, result}, 16'h000C);

    // Timeout with TIMEOUT = 64
    acquire(0, 2'b01, "to_gnt_r0");
    load_prog(0, 1);
    launch(0, 1, 1'b1, 16'h0000);
    chk("to_p_start", {31'd0, p_start}, 1);
    n = 0;
    while (p_nrst && n < 200) begin step(); n++; end
    chk("to_latency", n, 64);
    step();
    chk("to_abort_len", {31'd0, p_nrst}, 1);
    wait_done("to_done");

    // Reset in the middle of RUN
    acquire(1, 2'b10, "mr_gnt_r1");
    load_prog(1, 1);
    launch(1, 0, 1'b0, 16'h0000);
    ds0 = done_seen;
    repeat (10) step();
    chk("mr_busy_run", {31'd0, busy}, 1);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("mr_gnt", {30'd0, gnt}, 0);
      chk("mr_p_nrst", {31'd0, p_nrst}, 0);
      chk("mr_busy", {31'd0, busy}, 0);
      chk("mr_p_start", {31'd0, p_start}, 0);
    end
    rst = 1'b0;
    chk("mr_fall_p_nrst", {31'd0, p_nrst}, 0);
    step();
    chk("mr_release_p_nrst", {31'd0, p_nrst}, 1);
    chk("mr_no_done", done_seen, ds0);
    acquire(0, 2'b01, "mr_new_gnt");
    load_prog(0, 0);
    launch(0, 1, 1'b0, 16'h000C);
    wait_done("mr_new_done");

    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
